// File: rtl/ibex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibex_pkg
// Purpose  : Shared types for the instruction-side bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ibex_pkg;

  // Source of an instruction-side transaction; also the arbiter port index.
  typedef enum logic {
    INSTR_SRC_FETCH = 1'b0,
    INSTR_SRC_AUX   = 1'b1
  } instr_src_e;

  // The round-robin loser of the last contest is the opposite source.
  function automatic instr_src_e instr_src_other(input instr_src_e src);
    return (src == INSTR_SRC_FETCH) ? INSTR_SRC_AUX : INSTR_SRC_FETCH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_instr_src_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ibex_instr_src_fifo
// Purpose  : In-order FIFO of 1-bit source tags for granted transactions,
//            used to steer each response back to its requester.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_instr_src_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          ResetAll = 1'b0,
  localparam int unsigned CntW    = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  instr_src_e      push_src_i,
  input  logic            pop_i,
  output instr_src_e      head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  instr_src_e      mem_q [Depth];

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Pointer and occupancy tracking; simultaneous push and pop leave count as is.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  if (ResetAll) begin : g_reset_all
    // Tag storage with reset, for flows that require every flop to be reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) mem_q[i] <= INSTR_SRC_FETCH;
      end else if (push_i) begin
        mem_q[wr_ptr_q] <= push_src_i;
      end
    end
  end else begin : g_no_reset
    // Tag storage without reset; entries are only read after being written.
    always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_src_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));

endmodule
`default_nettype wire

// File: rtl/ibex_instr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_instr_bus_arbiter
// Purpose  : Round-robin arbiter sharing the instruction memory port between
//            the prefetch fetch port (0) and an auxiliary fetcher (1), with a
//            bounded number of outstanding transactions and in-order routing
//            of responses by source tag.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_instr_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  instr_src_e      sel;
  instr_src_e      sel_q;
  instr_src_e      rr_last_q;
  instr_src_e      head;
  logic            lock_q;
  logic [CntW-1:0] count;
  logic            full;
  logic            can_issue;
  logic            grant;
  logic            outstanding;
  logic            pop;

  // A full tag FIFO blocks issue; a same-cycle response does not free a slot.
  assign can_issue = ~full;

  // Selection: a pending ungranted request keeps its port, else round-robin.
  always_comb begin
    sel = INSTR_SRC_FETCH;
    if (lock_q) begin
      sel = sel_q;
    end else if (m0_req_i && m1_req_i) begin
      sel = instr_src_other(rr_last_q);
    end else if (m1_req_i) begin
      sel = INSTR_SRC_AUX;
    end
  end

  assign instr_req_o  = can_issue & (lock_q | m0_req_i | m1_req_i);
  assign instr_addr_o = (sel == INSTR_SRC_AUX) ? m1_addr_i : m0_addr_i;
  assign grant        = instr_req_o & instr_gnt_i;
  assign m0_gnt_o     = grant & (sel == INSTR_SRC_FETCH);
  assign m1_gnt_o     = grant & (sel == INSTR_SRC_AUX);

  // Lock an ungranted request; on grant release it and advance round-robin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      sel_q     <= INSTR_SRC_FETCH;
      rr_last_q <= INSTR_SRC_AUX;
    end else if (instr_req_o) begin
      if (instr_gnt_i) begin
        lock_q    <= 1'b0;
        rr_last_q <= sel;
      end else begin
        lock_q    <= 1'b1;
        sel_q     <= sel;
      end
    end
  end

  // Responses with nothing outstanding (e.g. for pre-reset grants) are dropped.
  assign outstanding = (count != '0);
  assign pop         = instr_rvalid_i & outstanding;

  ibex_instr_src_fifo #(
    .Depth    (MaxOutstanding),
    .ResetAll (ResetAll)
  ) u_src_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (grant),
    .push_src_i (sel),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .full_o     (full)
  );

  assign m0_rvalid_o = pop & (head == INSTR_SRC_FETCH);
  assign m1_rvalid_o = pop & (head == INSTR_SRC_AUX);
  assign m0_err_o    = instr_err_i & m0_rvalid_o;
  assign m1_err_o    = instr_err_i & m1_rvalid_o;
  assign m0_rdata_o  = instr_rdata_i;
  assign m1_rdata_o  = instr_rdata_i;

  assign busy_o = outstanding | instr_req_o;

  // A locked requester must hold its request until granted.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> ((sel_q == INSTR_SRC_AUX) ? m1_req_i : m0_req_i))
    else $error("locked requester dropped its request before grant");

  // A lock only forms with a free slot, so capacity cannot vanish while locked.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> can_issue)
    else $error("capacity exhausted while a request is locked");

  // Responses without an outstanding transaction are dropped; flag them.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> outstanding)
    else $warning("response received with no outstanding transaction, dropped");

endmodule
`default_nettype wire

// File: tb/tb_ibex_instr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_instr_bus_arbiter
// Purpose  : Self-checking bench: per-cycle vector table for request/grant
//            behaviour plus a source-tag scoreboard for response routing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_instr_bus_arbiter;

  logic        clk;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard of expected response sources, in grant order (0 = m0, 1 = m1).
  bit sb[$];

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;

  typedef struct packed {
    logic        rst;
    logic        m0r;
    logic        m1r;
    logic [31:0] a1;
    logic        gnt;
    logic        rv;
    logic        er;
    logic [31:0] rd;
    logic        eg0;
    logic        eg1;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  ibex_instr_bus_arbiter #(
    .MaxOutstanding (2),
    .ResetAll       (1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .m0_req_i       (m0_req_i),
    .m0_addr_i      (m0_addr_i),
    .m0_gnt_o       (m0_gnt_o),
    .m0_rvalid_o    (m0_rvalid_o),
    .m0_rdata_o     (m0_rdata_o),
    .m0_err_o       (m0_err_o),
    .m1_req_i       (m1_req_i),
    .m1_addr_i      (m1_addr_i),
    .m1_gnt_o       (m1_gnt_o),
    .m1_rvalid_o    (m1_rvalid_o),
    .m1_rdata_o     (m1_rdata_o),
    .m1_err_o       (m1_err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic m0r, input logic m1r, input logic [31:0] a1,
                              input logic gnt, input logic rv, input logic er,
                              input logic [31:0] rd, input logic eg0, input logic eg1,
                              input logic ereq, input logic [31:0] eaddr);
    vec_t v;
    v.rst = 1'b0; v.m0r = m0r; v.m1r = m1r; v.a1 = a1;
    v.gnt = gnt; v.rv = rv; v.er = er; v.rd = rd;
    v.eg0 = eg0; v.eg1 = eg1; v.ereq = ereq; v.eaddr = eaddr;
    return v;
  endfunction

  function automatic vec_t mkrst();
    vec_t v;
    v = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic idle_inputs();
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    m0_addr_i = A0;  m1_addr_i = A1;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    instr_err_i = 1'b0; instr_rdata_i = '0;
  endtask

  // Hold reset for a cycle with idle inputs, check the reset-state outputs.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    idle_inputs();
    sb.delete();
    @(negedge clk);
    chk1("rst_m0_gnt", m0_gnt_o, 1'b0);
    chk1("rst_m1_gnt", m1_gnt_o, 1'b0);
    chk1("rst_m0_rvalid", m0_rvalid_o, 1'b0);
    chk1("rst_m1_rvalid", m1_rvalid_o, 1'b0);
    chk1("rst_instr_req", instr_req_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // One cycle: drive after the edge, check at the falling edge.
  task automatic apply(input vec_t v);
    bit   src;
    logic exp_busy;
    if (v.rst) begin
      do_reset();
      return;
    end
    @(posedge clk);
    #1;
    m0_req_i       = v.m0r;
    m1_req_i       = v.m1r;
    m0_addr_i      = A0;
    m1_addr_i      = v.a1;
    instr_gnt_i    = v.gnt;
    instr_rvalid_i = v.rv;
    instr_err_i    = v.er;
    instr_rdata_i  = v.rd;
    @(negedge clk);
    exp_busy = (sb.size() != 0) | v.ereq;
    chk1("m0_gnt", m0_gnt_o, v.eg0);
    chk1("m1_gnt", m1_gnt_o, v.eg1);
    chk1("instr_req", instr_req_o, v.ereq);
    if (v.ereq) chk32("instr_addr", instr_addr_o, v.eaddr);
    chk1("busy", busy_o, exp_busy);
    if (v.rv && sb.size() != 0) begin
      src = sb.pop_front();
      chk1("m0_rvalid", m0_rvalid_o, !src);
      chk1("m1_rvalid", m1_rvalid_o, src);
      chk32("rdata", src ? m1_rdata_o : m0_rdata_o, v.rd);
      chk1("m0_err", m0_err_o, v.er & !src);
      chk1("m1_err", m1_err_o, v.er & src);
    end else begin
      chk1("m0_rvalid_idle", m0_rvalid_o, 1'b0);
      chk1("m1_rvalid_idle", m1_rvalid_o, 1'b0);
    end
    if (v.eg0) sb.push_back(1'b0);
    if (v.eg1) sb.push_back(1'b1);
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("init_m0_gnt", m0_gnt_o, 1'b0);
    chk1("init_m1_gnt", m1_gnt_o, 1'b0);
    chk1("init_instr_req", instr_req_o, 1'b0);
    chk1("init_busy", busy_o, 1'b0);
    chk1("init_m0_rvalid", m0_rvalid_o, 1'b0);
    chk1("init_m1_rvalid", m1_rvalid_o, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    //            m0r m1r a1        gnt rv er rdata         eg0 eg1 req addr
    // Port 0 alone, back-to-back grants with one-cycle response latency.
    vecs.push_back(mk(1, 0, A1,       1, 0, 0, 32'h0,        1, 0, 1, A0));
    vecs.push_back(mk(1, 0, A1,       1, 1, 0, 32'hDEADBEEF, 1, 0, 1, A0));
    vecs.push_back(mk(1, 0, A1,       1, 1, 0, 32'hDEADBEEF, 1, 0, 1, A0));
    vecs.push_back(mk(0, 0, A1,       0, 1, 0, 32'hDEADBEEF, 0, 0, 0, A0));
    vecs.push_back(mkrst());
    // Both ports every cycle: alternate starting with port 0.
    vecs.push_back(mk(1, 1, A1,       1, 0, 0, 32'h0,        1, 0, 1, A0));
    vecs.push_back(mk(1, 1, A1,       1, 1, 0, 32'h11111111, 0, 1, 1, A1));
    vecs.push_back(mk(1, 1, A1,       1, 1, 0, 32'h22222222, 1, 0, 1, A0));
    vecs.push_back(mk(1, 1, A1,       1, 1, 0, 32'h33333333, 0, 1, 1, A1));
    vecs.push_back(mk(0, 0, A1,       0, 1, 0, 32'h44444444, 0, 0, 0, A0));
    // Lock on port 0 while the memory stalls; port 1 address moves meanwhile.
    vecs.push_back(mk(1, 1, A1,       0, 0, 0, 32'h0,        0, 0, 1, A0));
    vecs.push_back(mk(1, 1, 32'h208,  0, 0, 0, 32'h0,        0, 0, 1, A0));
    vecs.push_back(mk(1, 1, 32'h20C,  0, 0, 0, 32'h0,        0, 0, 1, A0));
    vecs.push_back(mk(1, 1, A1,       1, 0, 0, 32'h0,        1, 0, 1, A0));
    vecs.push_back(mk(1, 1, A1,       1, 1, 0, 32'h55555555, 0, 1, 1, A1));
    // Lock on port 1 alone; port 0 joining must not steal the locked slot.
    vecs.push_back(mk(0, 1, A1,       0, 1, 0, 32'h66666666, 0, 0, 1, A1));
    vecs.push_back(mk(1, 1, A1,       0, 0, 0, 32'h0,        0, 0, 1, A1));
    vecs.push_back(mk(1, 1, A1,       1, 0, 0, 32'h0,        0, 1, 1, A1));
    // Error response on a port 1 tag.
    vecs.push_back(mk(0, 0, A1,       0, 1, 1, 32'h77777777, 0, 0, 0, A0));
    // Capacity: two outstanding blocks issue; a response frees a slot next cycle.
    vecs.push_back(mk(1, 0, A1,       1, 0, 0, 32'h0,        1, 0, 1, A0));
    vecs.push_back(mk(1, 0, A1,       1, 0, 0, 32'h0,        1, 0, 1, A0));
    vecs.push_back(mk(1, 0, A1,       1, 0, 0, 32'h0,        0, 0, 0, A0));
    vecs.push_back(mk(1, 0, A1,       1, 1, 0, 32'h88888888, 0, 0, 0, A0));
    vecs.push_back(mk(1, 0, A1,       1, 0, 0, 32'h0,        1, 0, 1, A0));
    vecs.push_back(mk(0, 0, A1,       0, 1, 0, 32'h99999999, 0, 0, 0, A0));
    vecs.push_back(mk(0, 1, A1,       1, 0, 0, 32'h0,        0, 1, 1, A1));
    // Reset with two outstanding; late responses are dropped.
    vecs.push_back(mkrst());
    vecs.push_back(mk(0, 0, A1,       0, 1, 0, 32'hAAAAAAAA, 0, 0, 0, A0));
    vecs.push_back(mk(0, 0, A1,       0, 1, 1, 32'hBBBBBBBB, 0, 0, 0, A0));
    vecs.push_back(mk(1, 1, A1,       1, 0, 0, 32'h0,        1, 0, 1, A0));
    vecs.push_back(mk(1, 1, A1,       1, 0, 0, 32'h0,        0, 1, 1, A1));
    vecs.push_back(mk(1, 1, A1,       1, 0, 0, 32'h0,        0, 0, 0, A0));
    vecs.push_back(mk(0, 0, A1,       0, 1, 0, 32'hCCCCCCCC, 0, 0, 0, A0));
    vecs.push_back(mk(0, 0, A1,       0, 1, 1, 32'hDDDDDDDD, 0, 0, 0, A0));

    foreach (vecs[i]) apply(vecs[i]);

    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk1("end_busy", busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
